// File: rtl/osc_window_counter.sv
// Counts synchronized ring-oscillator rising edges per COUNT_DONE window; result is registered on the closing edge, 3-edge input latency.
// No backpressure: COUNTER_VALID is a single-cycle pulse, and the consumer must take it in that cycle.
module osc_window_counter #(
   parameter int AVG_LOG2 = 0
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       OSC_IN,
   input  logic       COUNT_DONE,
   input  logic       FORCE_RST,
   output logic [7:0] COUNTER,
   output logic       COUNTER_VALID,
   output logic       OVERFLOW
);

   localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int SUM_W = 8 + AVG_LOG2;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

   typedef enum logic [1:0] {SYNC, DISCARD, MEASURE} state_t;

   state_t           state;
   logic [1:0]       sync_cnt;
   logic             s1, s2, s3;
   logic             rise;
   logic [7:0]       acc;
   logic             sat;
   logic [SUM_W-1:0] sum;
   logic [IDX_W-1:0] idx;
   logic [8:0]       wide;
   logic             w_sat;
   logic [7:0]       w;
   logic [SUM_W-1:0] total;
   logic             idx_last;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= OSC_IN;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

   // An edge landing in the COUNT_DONE cycle belongs to the window being closed.
   assign wide     = {1'b0, acc} + {8'd0, rise};
   assign w_sat    = wide[8];
   assign w        = w_sat ? 8'hFF : wide[7:0];
   assign total    = sum + SUM_W'(w);
   assign idx_last = (idx == IDX_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= SYNC;
         sync_cnt      <= 2'd0;
         acc           <= 8'd0;
         sat           <= 1'b0;
         sum           <= '0;
         idx           <= '0;
         COUNTER       <= 8'd0;
         COUNTER_VALID <= 1'b0;
         OVERFLOW      <= 1'b0;
      end else begin
         COUNTER_VALID <= 1'b0;
         if (FORCE_RST) begin
            // Wins over a coincident COUNT_DONE; COUNTER keeps its last value.
            state    <= SYNC;
            sync_cnt <= 2'd0;
            acc      <= 8'd0;
            sat      <= 1'b0;
            sum      <= '0;
            idx      <= '0;
            OVERFLOW <= 1'b0;
         end else begin
            case (state)
               SYNC: begin
                  if (sync_cnt == 2'd2) begin
                     state    <= DISCARD;
                     sync_cnt <= 2'd0;
                  end else begin
                     sync_cnt <= sync_cnt + 2'd1;
                  end
               end
               DISCARD: begin
                  if (COUNT_DONE) state <= MEASURE;
               end
               MEASURE: begin
                  if (COUNT_DONE) begin
                     acc      <= 8'd0;
                     sat      <= 1'b0;
                     OVERFLOW <= OVERFLOW | sat | w_sat;
                     if (idx_last) begin
                        COUNTER       <= total[AVG_LOG2 +: 8];
                        COUNTER_VALID <= 1'b1;
                        sum           <= '0;
                        idx           <= '0;
                     end else begin
                        sum <= total;
                        idx <= idx + 1'b1;
                     end
                  end else if (rise) begin
                     if (acc == 8'hFF) sat <= 1'b1;
                     else              acc <= acc + 8'd1;
                  end
               end
               default: state <= SYNC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_osc_window_counter.sv
// Directed bench for osc_window_counter: one instance without averaging, one averaging over 4 windows.
// Expected results are queued as windows close and checked when COUNTER_VALID appears.
module tb_osc_window_counter;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       OSC_IN = 1'b0;
   logic       COUNT_DONE = 1'b0;
   logic       FORCE_RST = 1'b0;
   logic [7:0] counter0, counter2;
   logic       valid0, valid2, ovf0, ovf2;

   always #5 CLK = ~CLK;

   osc_window_counter #(.AVG_LOG2(0)) dut0 (
      .CLK(CLK), .RST_N(RST_N), .OSC_IN(OSC_IN), .COUNT_DONE(COUNT_DONE), .FORCE_RST(FORCE_RST),
      .COUNTER(counter0), .COUNTER_VALID(valid0), .OVERFLOW(ovf0));

   osc_window_counter #(.AVG_LOG2(2)) dut2 (
      .CLK(CLK), .RST_N(RST_N), .OSC_IN(OSC_IN), .COUNT_DONE(COUNT_DONE), .FORCE_RST(FORCE_RST),
      .COUNTER(counter2), .COUNTER_VALID(valid2), .OVERFLOW(ovf2));

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q2[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // Reference model state: OSC history (synchronizer view), window tally, phase.
   logic       h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
   int         win = 0;
   int         sync_left = 3;
   bit         meas = 1'b0;
   bit         ovf_exp = 1'b0;
   int         s2sum = 0;
   int         s2idx = 0;
   logic [7:0] last0 = 8'd0;
   logic [7:0] last2 = 8'd0;
   int         ph = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   // One clock cycle of stimulus; updates the model with what this cycle should produce.
   task automatic step(input logic osc, input logic cd, input logic fr);
      logic r;
      int   w;
      exp_t e;
      OSC_IN     = osc;
      COUNT_DONE = cd;
      FORCE_RST  = fr;
      r = h2 & ~h3;
      if (fr) begin
         sync_left = 3; meas = 1'b0; win = 0; s2sum = 0; s2idx = 0; ovf_exp = 1'b0;
      end else if (sync_left > 0) begin
         sync_left--;
         win = 0;
      end else if (cd) begin
         if (meas) begin
            w = win + int'(r);
            if (w > 255) begin
               w = 255;
               ovf_exp = 1'b1;
            end
            e.val = 8'(w);
            e.cyc = cyc + 1;
            q0.push_back(e);
            last0 = 8'(w);
            s2sum += w;
            s2idx++;
            if (s2idx == 4) begin
               e.val = 8'(s2sum / 4);
               q2.push_back(e);
               last2 = e.val;
               s2sum = 0;
               s2idx = 0;
            end
         end
         meas = 1'b1;
         win  = 0;
      end else if (meas) begin
         win += int'(r);
      end
      @(posedge CLK);
      #1;
      h3 = h2; h2 = h1; h1 = osc;
      cyc++;
   endtask

   task automatic run_sq(input int n, input int period, input bit cd_end);
      for (int i = 0; i < n; i++) begin
         step((ph % period) < (period / 2), cd_end && (i == n - 1), 1'b0);
         ph++;
      end
   endtask

   // k single-cycle OSC pulses every 4 cycles, then quiet; COUNT_DONE on the last cycle.
   task automatic run_pulses(input int k, input int len);
      for (int i = 0; i < len; i++)
         step((i % 4 == 0) && (i / 4 < k), i == len - 1, 1'b0);
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (valid0) begin
         checks++;
         assert (q0.size() != 0) else begin
            errors++;
            $error("FAIL valid0_unexpected: observed COUNTER=%0d with no result pending", counter0);
         end
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("counter0_value", counter0, e.val);
            chk("counter0_cycle", cyc, e.cyc);
         end
      end
      if (valid2) begin
         checks++;
         assert (q2.size() != 0) else begin
            errors++;
            $error("FAIL valid2_unexpected: observed COUNTER=%0d with no result pending", counter2);
         end
         if (q2.size() != 0) begin
            e = q2.pop_front();
            chk("counter2_value", counter2, e.val);
            chk("counter2_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #2;
      chk("rst_counter0", counter0, 0);
      chk("rst_valid0", valid0, 0);
      chk("rst_ovf0", ovf0, 0);
      chk("rst_counter2", counter2, 0);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST_N = 1'b1;

      // CLK/4 square wave, 100-cycle windows, after one discarded window
      run_sq(10, 4, 1'b1);
      chk("t1_discard_novalid", valid0, 0);
      run_sq(100, 4, 1'b1);
      chk("t1_valid0", valid0, 1);
      run_sq(100, 4, 1'b1);
      chk("t1_ovf0", ovf0, 0);

      // CLK/2 saturates; overflow stays set through a CLK/8 window
      ph = 0;
      run_sq(600, 2, 1'b1);
      chk("t2_counter_sat", counter0, 255);
      chk("t2_ovf0", ovf0, 1);
      ph = 0;
      run_sq(600, 8, 1'b1);
      chk("t2_ovf0_sticky", ovf0, 1);
      chk("t2_ovf2_sticky", ovf2, 1);

      // FORCE_RST coincident with COUNT_DONE mid-measure
      for (int i = 0; i < 20; i++) step(i % 4 == 0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      chk("t4_novalid", valid0, 0);
      chk("t4_counter0_hold", counter0, last0);
      chk("t4_counter2_hold", counter2, last2);
      chk("t4_ovf_cleared", ovf0, 0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("t4_sync_ignores_done", valid0, 0);
      step(1'b0, 1'b1, 1'b0);
      chk("t4_discard_novalid", valid0, 0);

      // Averaging over windows of 10, 20, 30, 41 edges
      run_pulses(10, 48);
      chk("t3_w1_valid0", valid0, 1);
      chk("t3_w1_novalid2", valid2, 0);
      run_pulses(20, 88);
      chk("t3_w2_novalid2", valid2, 0);
      run_pulses(30, 128);
      chk("t3_w3_novalid2", valid2, 0);
      run_pulses(41, 172);
      chk("t3_valid2", valid2, 1);
      chk("t3_counter2_avg", counter2, 25);
      chk("t3_counter0_last", counter0, 41);

      // Edge whose rise lands in the COUNT_DONE cycle, then a 1-cycle window
      for (int i = 0; i < 50; i++)
         step(((i % 4 == 0) && (i / 4 < 11)) || (i == 47), i == 49, 1'b0);
      chk("t5_edge_in_closing", counter0, 12);
      step(1'b0, 1'b1, 1'b0);
      chk("t5_backtoback_valid", valid0, 1);
      chk("t5_next_starts_zero", counter0, 0);
      run_pulses(5, 28);
      chk("t5_after", counter0, 5);

      // Asynchronous reset mid-window with 40 edges accumulated
      for (int i = 0; i < 170; i++) step((i % 4 == 0) && (i / 4 < 40), 1'b0, 1'b0);
      #1;
      RST_N = 1'b0;
      #1;
      chk("t6_counter0", counter0, 0);
      chk("t6_valid0", valid0, 0);
      chk("t6_ovf0", ovf0, 0);
      chk("t6_counter2", counter2, 0);
      RST_N = 1'b1;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      win = 0; sync_left = 3; meas = 1'b0; ovf_exp = 1'b0;
      s2sum = 0; s2idx = 0; last0 = 8'd0; last2 = 8'd0;
      run_pulses(5, 28);
      chk("t6_discard_novalid", valid0, 0);
      run_pulses(7, 36);
      chk("t6_first_result", counter0, 7);
      chk("t6_ovf_model", ovf0, ovf_exp);

      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
      chk("q0_drained", q0.size(), 0);
      chk("q2_drained", q2.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
